adc_volt_disp: RTL and testbench



---
 rtl/adc_pkg.sv | 45 ++++
 rtl/adc_volt_disp_seg7_scan.sv | 43 ++++
 rtl/adc_volt_disp.sv | 130 +++++++++++++
 tb/tb_adc_volt_disp.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC millivolt display path.
// Holds the FSM encoding, datapath widths and the 7-segment LUT.
package adc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_BCD,
    S_DONE
  } state_t;

  localparam int PROD_W = 20;
  localparam int MV_W   = 12;

  localparam logic [PROD_W-1:0] RND     = 20'd127;
  localparam logic [8:0]        DIVISOR = 9'd255;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7_lut(
    input logic [3:0] n
  );
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      4'hF: p = 7'h0E;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/adc_volt_disp_seg7_scan.sv
// Multiplexed 4-digit 7-segment scanner with registered seg/sel.
// Digit index 3 drives sel[3]; the decimal point follows dp_idx.
module seg7_scan
  import adc_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [1:0]  dp_idx,
  output logic [7:0]  seg,
  output logic [3:0]  sel
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_n;
  logic          wrap;
  logic [3:0]    nib;

  assign wrap  = (cnt == CW'(SCAN_DIV - 1));
  assign idx_n = wrap ? idx + 2'd1 : idx;
  assign nib   = digits[{idx_n, 2'b00} +: 4];

  // seg/sel follow the next index so they switch on the wrap edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
      seg <= 8'hC0;
      sel <= 4'b1110;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      idx <= idx_n;
      seg <= {(idx_n != dp_idx), seg7_lut(nib)};
      sel <= ~(4'b0001 << idx_n);
    end
  end

endmodule

// File: rtl/adc_volt_disp.sv
// Captures ADC codes, scales to mV via sequential divide, converts
// to BCD with double-dabble and drives a V.mmm 7-segment display.
module adc_volt_disp
  import adc_pkg::*;
#(
  parameter int VREF_MV  = 3300,
  parameter int SCAN_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs_n,
  input  logic [7:0]      data,
  output logic [MV_W-1:0] mv,
  output logic            mv_valid,
  output logic [7:0]      seg,
  output logic [3:0]      sel
);

  localparam logic [PROD_W-1:0] VREF_P   = PROD_W'(VREF_MV);
  localparam logic [4:0]        DIV_LAST = 5'(PROD_W - 1);
  localparam logic [4:0]        BCD_LAST = 5'(MV_W - 1);

  state_t state, state_n;

  logic              cs_n_d;
  logic              capture;
  logic [7:0]        code;
  logic              pending;
  logic [PROD_W-1:0] prod;
  logic [7:0]        rem;
  logic [4:0]        cnt;
  logic [MV_W-1:0]   bin;
  logic [15:0]       bcd;
  logic [15:0]       bcd_adj;
  logic [15:0]       digits;
  logic [8:0]        trial;
  logic [8:0]        rem_sub;
  logic              ge;

  assign capture = !cs_n_d && cs_n;

  assign trial   = {rem, prod[PROD_W-1]};
  assign ge      = (trial >= DIVISOR);
  assign rem_sub = trial - DIVISOR;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (capture || pending) state_n = S_MUL;
      S_MUL:  state_n = S_DIV;
      S_DIV:  if (cnt == DIV_LAST) state_n = S_BCD;
      S_BCD:  if (cnt == BCD_LAST) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n_d   <= 1'b1;
      code     <= '0;
      pending  <= 1'b0;
      prod     <= '0;
      rem      <= '0;
      cnt      <= '0;
      bin      <= '0;
      bcd      <= '0;
      digits   <= '0;
      mv       <= '0;
      mv_valid <= 1'b0;
    end else begin
      cs_n_d   <= cs_n;
      mv_valid <= 1'b0;
      if (capture) code <= data;
      // A capture outside IDLE is remembered once; newer ones overwrite code
      if (state == S_IDLE) pending <= 1'b0;
      else if (capture)    pending <= 1'b1;
      unique case (state)
        S_MUL: begin
          prod <= PROD_W'(code) * VREF_P + RND;
          rem  <= '0;
          cnt  <= '0;
          bcd  <= '0;
        end
        S_DIV: begin
          prod <= {prod[PROD_W-2:0], ge};
          rem  <= ge ? rem_sub[7:0] : trial[7:0];
          cnt  <= (cnt == DIV_LAST) ? 5'd0 : cnt + 5'd1;
          if (cnt == DIV_LAST) bin <= {prod[MV_W-2:0], ge};
        end
        S_BCD: begin
          bcd <= {bcd_adj[14:0], bin[MV_W-1]};
          bin <= {bin[MV_W-2:0], 1'b0};
          cnt <= (cnt == BCD_LAST) ? 5'd0 : cnt + 5'd1;
        end
        S_DONE: begin
          mv       <= prod[MV_W-1:0];
          digits   <= bcd;
          mv_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .digits(digits),
    .dp_idx(2'd3),
    .seg   (seg),
    .sel   (sel)
  );

endmodule

// File: tb/tb_adc_volt_disp.sv
// Scoreboard bench: two DUTs (3300 mV and 4095 mV reference)
// share stimulus; a monitor pops expected mV and cycle per strobe.
module tb_adc_volt_disp;

  typedef struct {
    logic [11:0] mv;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic [7:0]  data;
  logic [11:0] mv_a, mv_b;
  logic        mv_valid_a, mv_valid_b;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  sel_a, sel_b;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t qa[$];
  exp_t qb[$];

  adc_volt_disp #(.VREF_MV(3300), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .cs_n(cs_n), .data(data),
    .mv(mv_a), .mv_valid(mv_valid_a), .seg(seg_a), .sel(sel_a)
  );

  adc_volt_disp #(.VREF_MV(4095), .SCAN_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .cs_n(cs_n), .data(data),
    .mv(mv_b), .mv_valid(mv_valid_b), .seg(seg_b), .sel(sel_b)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, want, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mv_valid_a) begin
      if (qa.size() == 0) begin
        chk("unexpected_valid_a", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("mv_a", int'(mv_a), int'(e.mv));
        chk("latency_a", cyc, e.cyc);
      end
    end
    if (mv_valid_b) begin
      if (qb.size() == 0) begin
        chk("unexpected_valid_b", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("mv_b", int'(mv_b), int'(e.mv));
        chk("latency_b", cyc, e.cyc);
      end
    end
  end

  task automatic capture(input logic [7:0] d, input logic [11:0] ea,
                         input logic [11:0] eb, input bit push,
                         input int extra);
    @(negedge clk);
    data = d;
    cs_n = 1'b0;
    @(negedge clk);
    cs_n = 1'b1;
    if (push) begin
      qa.push_back('{ea, cyc + 35 + extra});
      qb.push_back('{eb, cyc + 35 + extra});
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_pending_a"}, qa.size(), 0);
    chk({name, "_pending_b"}, qb.size(), 0);
    qa.delete();
    qb.delete();
    @(negedge clk);
  endtask

  task automatic disp(input bit which, input logic [7:0] e3,
                      input logic [7:0] e2, input logic [7:0] e1,
                      input logic [7:0] e0);
    logic [3:0] s, prev;
    logic [7:0] g;
    int run;
    bit seen;
    run = 0;
    seen = 0;
    prev = 4'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s = which ? sel_b : sel_a;
      g = which ? seg_b : seg_a;
      case (s)
        4'b0111: chk("seg_d3", int'(g), int'(e3));
        4'b1011: chk("seg_d2", int'(g), int'(e2));
        4'b1101: chk("seg_d1", int'(g), int'(e1));
        4'b1110: chk("seg_d0", int'(g), int'(e0));
        default: chk("sel_onehot", int'(s), 15);
      endcase
      if (i > 0 && s != prev) begin
        chk("sel_order", int'(s), int'({prev[2:0], prev[3]}));
        if (seen) chk("scan_period", run, 4);
        seen = 1;
        run = 0;
      end
      run++;
      prev = s;
    end
  endtask

  initial begin
    rst = 1'b1;
    cs_n = 1'b1;
    data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_mv", int'(mv_a), 0);
    chk("rst_valid", int'(mv_valid_a), 0);
    chk("rst_sel", int'(sel_a), 4'hE);
    chk("rst_seg", int'(seg_a), 8'hC0);
    rst = 1'b0;

    capture(8'h66, 12'd1320, 12'd1638, 1, 0);
    drain("c66");
    disp(0, 8'h79, 8'hB0, 8'hA4, 8'hC0);

    capture(8'hAA, 12'd2200, 12'd2730, 1, 0);
    drain("cAA");
    capture(8'hFF, 12'd3300, 12'd4095, 1, 0);
    drain("cFF");
    disp(1, 8'h19, 8'hC0, 8'h90, 8'h92);
    capture(8'h00, 12'd0, 12'd0, 1, 0);
    drain("c00");
    disp(0, 8'h40, 8'hC0, 8'hC0, 8'hC0);
    capture(8'h01, 12'd13, 12'd16, 1, 0);
    drain("c01");

    capture(8'h66, 12'd1320, 12'd1638, 1, 0);
    repeat (8) @(negedge clk);
    capture(8'hAA, 12'd2200, 12'd2730, 1, 25);
    drain("pend");

    capture(8'hFF, 12'd0, 12'd0, 0, 0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_mv_a", int'(mv_a), 0);
    chk("abort_mv_b", int'(mv_b), 0);
    chk("abort_valid", int'(mv_valid_a), 0);
    chk("abort_sel", int'(sel_a), 4'hE);
    chk("abort_seg", int'(seg_a), 8'hC0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    capture(8'h66, 12'd1320, 12'd1638, 1, 0);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
